// File: rtl/uart_rx.sv
// 8N1 UART receiver with programmable bit period and a ready/acknowledge holding register.
// One bit lasts cycles_per_bit+1 clocks; bits are sampled near mid-bit, LSB first.
module uart_rx #(
    parameter logic [15:0] UART_SPEED_DEFAULT = 16'h186a,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] data,
    input  logic        set,
    input  logic        rd,
    output logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            cpb_q, cpb_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   good_byte;
    logic                   rx_s;
    logic [15:0]            half;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign half = {1'b0, cpb_q[15:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '1;
            state_q     <= StIdle;
            cpb_q       <= UART_SPEED_DEFAULT;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q     <= state_d;
            cpb_q       <= cpb_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpb_d       = cpb_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = rx_ready_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        good_byte   = 1'b0;

        // A rate change abandons any frame in flight.
        if (set) begin
            cpb_d   = data;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == half) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = StData;
                            bit_idx_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == cpb_q) begin
                        shift_d[bit_idx_q] = rx_s;
                        cnt_d              = '0;
                        if (bit_idx_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == cpb_q) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            good_byte  = 1'b1;
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A new byte beats a simultaneous acknowledge.
        if (good_byte) begin
            rx_ready_d = 1'b1;
            if (rd) begin
                overrun_d = 1'b0;
            end else if (rx_ready_q) begin
                overrun_d = 1'b1;
            end
        end else if (rd) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ready  = rx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's 16-bit-configurable UART transmitter.
- Samples the asynchronous serial input, recovers LSB-first bytes and presents them through a ready/acknowledge holding register.
- Bit timing uses the same cycles_per_bit semantics as the transmitter: one bit = cycles_per_bit+1 clk cycles, reprogrammed by a `set` strobe.
- Sits between the pad and the command/host logic.

Parameters:
- UART_SPEED_DEFAULT, 16'h186a, cycles_per_bit value loaded at reset.
- SYNC_STAGES, 2, flops in the rx metastability synchronizer (min 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial line, asynchronous to clk; idle high.
- data  in  16  new cycles_per_bit value, used only when set=1.
- set  in  1  load data into cycles_per_bit.
- rd  in  1  consumer acknowledge; clears rx_ready and overrun.
- rx_data  out  8  last good byte; holds until the next good byte.
- rx_ready  out  1  level: unread byte present in rx_data.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: good byte arrived while rx_ready=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, any time, including mid-frame):
  - rx_data=0, rx_ready=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, cycles_per_bit=UART_SPEED_DEFAULT, counters=0.
  - Synchronizer flops preset to 1.
- rx passes through SYNC_STAGES flops; rx_s is the synchronizer output. All decisions use rx_s only.
- half = cycles_per_bit >> 1 (floor). cnt is a 16-bit counter; bit_idx is 3 bits.
- set=1 has priority over the FSM:
  - cycles_per_bit <= data; state <= IDLE; cnt <= 0; any partial frame is discarded.
  - rx_ready, rx_data and overrun are unchanged.
  - rd is still honoured in the same cycle.
- FSM:
  - IDLE: rx_s=0 -> START, cnt<=0.
  - START: cnt==half -> if rx_s=0 then DATA, cnt<=0, bit_idx<=0; else IDLE (false start, no flags). Otherwise cnt++.
  - DATA: cnt==cycles_per_bit -> shift[bit_idx]<=rx_s, cnt<=0; bit_idx==7 -> STOP, else bit_idx++. Otherwise cnt++.
  - STOP: cnt==cycles_per_bit ->
    - rx_s=1: rx_data<=shift, rx_valid pulse, rx_ready<=1, then IDLE.
    - rx_s=0: frame_err pulse, rx_data unchanged, then BREAK.
    - Otherwise cnt++.
  - BREAK: wait for rx_s=1, then IDLE. busy stays high.
- Timing: if rx_s is first seen low at edge E0:
  - bit k (0..7) is sampled at E0+half+1+(k+1)(cycles_per_bit+1);
  - rx_valid/frame_err is asserted at the edge after E0+half+1+9(cycles_per_bit+1);
  - pin-to-rx_s latency is SYNC_STAGES cycles.
- Holding register:
  - rd=1 clears rx_ready and overrun next cycle.
  - A good byte with rx_ready=1 and rd=0 sets overrun=1 and overwrites rx_data.
  - A good byte in the same cycle as rd=1: new byte wins (rx_ready stays 1, overrun=0).
  - rd with rx_ready=0 has no effect.
- Back-to-back frames: IDLE is reached at the stop sample, so a start bit immediately after a one-period stop bit is accepted.
- cycles_per_bit=0 or 1 is legal: half=0, sampling occurs every cycle or every two cycles.

Test Plan:
1. set=1, data=15 (16-cycle bits); drive 8N1 frame 0xA5 -> rx_valid single pulse, rx_data=8'hA5, rx_ready=1, frame_err=0, busy low afterwards; rd -> rx_ready=0.
2. Back-to-back 0x00 then 0xFF with no idle gap, rd after each -> two rx_valid pulses exactly 160 cycles apart, data 00 then FF, overrun=0.
3. rx low for 4 cycles then high (bit period 16) -> returns to IDLE, no rx_valid, no frame_err; a following 0x3C frame is received correctly.
4. Frame 0x55 with stop bit low, then line held low 40 cycles -> frame_err pulse, rx_data/rx_ready unchanged, busy high until rx returns high, then IDLE.
5. Two good frames 0x11, 0x22 without rd -> overrun=1, rx_data=8'h22; rd -> rx_ready=0, overrun=0. Repeat with rd coincident with the second rx_valid -> rx_ready=1, overrun=0.
6. Mid-frame events:
   - set=1 at bit 3 -> FSM IDLE, no pulse; the next frame is received at the new rate.
   - reset=0 at bit 5 -> all outputs at reset values, cycles_per_bit=16'h186a.
